// File: rtl/half_adder_pkg.sv
// Shared types and limits for the registered lane-parallel half adder.
// Latency: none (package only).
// Backpressure: none (package only).
package half_adder_pkg;

    localparam int HA_MAX_WIDTH   = 64;
    localparam int HA_MAX_LATENCY = 4;

    // One lane's result as it travels down the pipeline.
    typedef struct packed {
        logic sum;
        logic carry;
    } ha_result_t;

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit combinational half adder: sum = a ^ b, carry = a & b.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder_behav.sv
// Lane-parallel half adder with a LATENCY-deep register pipeline and valid chain.
// Latency: LATENCY cycles from sampling edge to visible result; one result per clock.
// Backpressure: none; outputs are never stalled. Optional macro HALF_ADDER_CARRY_CNT_EN adds carry_cnt.
module half_adder_behav
    import half_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    output logic [31:0]      carry_cnt
`endif
);

    logic       [WIDTH-1:0] cell_sum;
    logic       [WIDTH-1:0] cell_carry;
    ha_result_t [WIDTH-1:0] cell_res;
    ha_result_t [WIDTH-1:0] pipe [LATENCY];
    logic       [LATENCY-1:0] vld;

    // One independent cell per lane; lanes never exchange carries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (cell_sum[i]),
            .carry (cell_carry[i])
        );
    end

    // Pack the per-lane cell outputs into pipeline records.
    always_comb begin
        cell_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cell_res[i].sum   = cell_sum[i];
            cell_res[i].carry = cell_carry[i];
        end
    end

    // Pipeline: data stages load only when their incoming valid is set, so
    // bubbles hold the old value and X on idle inputs never reaches the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                pipe[0] <= cell_res;
            end
            for (int s = 1; s < LATENCY; s++) begin
                vld[s] <= vld[s-1];
                if (vld[s-1]) begin
                    pipe[s] <= pipe[s-1];
                end
            end
        end
    end

    // Unpack the last stage onto the output buses.
    always_comb begin
        sum   = '0;
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = pipe[LATENCY-1][i].sum;
            carry[i] = pipe[LATENCY-1][i].carry;
        end
    end

    assign out_valid = vld[LATENCY-1];

`ifdef HALF_ADDER_CARRY_CNT_EN
    // Count emitted results with any carry bit set; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (out_valid && (|carry) && (carry_cnt != 32'hFFFF_FFFF)) begin
            carry_cnt <= carry_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_half_adder_behav.sv
// Directed self-checking bench: single-lane LATENCY=1 instance and 8-lane LATENCY=3 instance.
// Latency: checks at #1 after each rising edge.
// Backpressure: none exercised (the design has none).
module tb_half_adder_behav;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Single-lane, LATENCY=1 instance
    logic       rst1, iv1, ov1;
    logic [0:0] a1, b1, s1, c1;
    // Eight-lane, LATENCY=3 instance
    logic       rst8, iv8, ov8;
    logic [7:0] a8, b8, s8, c8;
`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [31:0] cnt1, cnt8;
`endif

    half_adder_behav #(.WIDTH(1), .LATENCY(1)) dut1 (
        .sum       (s1),
        .carry     (c1),
        .a         (a1),
        .b         (b1),
        .clk       (clk),
        .rst       (rst1),
        .in_valid  (iv1),
        .out_valid (ov1)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .carry_cnt (cnt1)
`endif
    );

    half_adder_behav #(.WIDTH(8), .LATENCY(3)) dut8 (
        .sum       (s8),
        .carry     (c8),
        .a         (a8),
        .b         (b8),
        .clk       (clk),
        .rst       (rst8),
        .in_valid  (iv8),
        .out_valid (ov8)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .carry_cnt (cnt8)
`endif
    );

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tv[4];
        logic [5:0] pat;

        tv[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        tv[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        tv[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        tv[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        // Reset state
        rst1 = 1'b1; iv1 = 1'b0; a1 = '0; b1 = '0;
        rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0;
        tick();
        chk("rst1_sum",   64'(s1),  64'd0);
        chk("rst1_carry", 64'(c1),  64'd0);
        chk("rst1_ovld",  64'(ov1), 64'd0);
        chk("rst8_sum",   64'(s8),  64'd0);
        chk("rst8_carry", 64'(c8),  64'd0);
        chk("rst8_ovld",  64'(ov8), 64'd0);

        // Reset beats in_valid on the same edge
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1; rst1 = 1'b1;
        tick();
        chk("rstpri_sum",   64'(s1),  64'd0);
        chk("rstpri_carry", 64'(c1),  64'd0);
        chk("rstpri_ovld",  64'(ov1), 64'd0);
        rst1 = 1'b0;
        tick();
        chk("postrst_ovld",  64'(ov1), 64'd1);
        chk("postrst_sum",   64'(s1),  64'd0);
        chk("postrst_carry", 64'(c1),  64'd1);

        // Exhaustive truth table, back-to-back
        for (int i = 0; i < 4; i++) begin
            a1 = tv[i].a; b1 = tv[i].b; iv1 = 1'b1;
            tick();
            chk($sformatf("tt%0d_sum", i),   64'(s1),  64'(tv[i].s));
            chk($sformatf("tt%0d_carry", i), 64'(c1),  64'(tv[i].c));
            chk($sformatf("tt%0d_ovld", i),  64'(ov1), 64'd1);
        end

        // Idle cycle with X operands: no valid, outputs hold last result (11)
        iv1 = 1'b0; a1 = 'x; b1 = 'x;
        tick();
        chk("bubx_ovld",  64'(ov1), 64'd0);
        chk("bubx_sum",   64'(s1),  64'd0);
        chk("bubx_carry", 64'(c1),  64'd1);

`ifdef HALF_ADDER_CARRY_CNT_EN
        // Carry counter: 00, 11, 01, 11 -> 2
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        chk("cnt_rst0", 64'(cnt1), 64'd0);
        for (int i = 0; i < 4; i++) begin
            a1 = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            b1 = (i == 0) ? 1'b0 : 1'b1;
            iv1 = 1'b1;
            tick();
        end
        iv1 = 1'b0; a1 = '0; b1 = '0;
        tick();
        chk("cnt_two", 64'(cnt1), 64'd2);
        tick();
        chk("cnt_hold", 64'(cnt1), 64'd2);
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        chk("cnt_clr", 64'(cnt1), 64'd0);
`endif

        // Multi-lane, LATENCY=3
        rst8 = 1'b0;
        a8 = 8'hF0; b8 = 8'hCC; iv8 = 1'b1;
        tick();
        iv8 = 1'b0; a8 = 'x; b8 = 'x;
        chk("ml_e1_ovld", 64'(ov8), 64'd0);
        tick();
        chk("ml_e2_ovld", 64'(ov8), 64'd0);
        tick();
        chk("ml_e3_ovld",  64'(ov8), 64'd1);
        chk("ml_e3_sum",   64'(s8),  64'h3C);
        chk("ml_e3_carry", 64'(c8),  64'hC0);
        tick();
        chk("ml_e4_ovld",  64'(ov8), 64'd0);
        chk("ml_e4_hold",  64'(s8),  64'h3C);

        // Bubbles: in_valid 1,0,1 -> out_valid 1,0,1 three cycles later
        pat = 6'b000101;
        for (int k = 0; k < 6; k++) begin
            iv8 = pat[k];
            a8  = pat[k] ? 8'hFF : 8'hxx;
            b8  = pat[k] ? 8'h01 : 8'hxx;
            tick();
            if (k >= 2) begin
                chk($sformatf("bub%0d_ovld", k), 64'(ov8), 64'(pat[k-2]));
                if (pat[k-2]) begin
                    chk($sformatf("bub%0d_sum", k),   64'(s8), 64'hFE);
                    chk($sformatf("bub%0d_carry", k), 64'(c8), 64'h01);
                end
            end
        end
        iv8 = 1'b0;

        // Mid-operation reset discards two in-flight results
        a8 = 8'hAA; b8 = 8'hFF; iv8 = 1'b1;
        tick();
        a8 = 8'h0F; b8 = 8'h0F;
        tick();
        iv8 = 1'b0; rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        chk("mid_rst_ovld", 64'(ov8), 64'd0);
        chk("mid_rst_sum",  64'(s8),  64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("mid_after%0d_ovld", k), 64'(ov8), 64'd0);
        end
`ifdef HALF_ADDER_CARRY_CNT_EN
        chk("mid_cnt8", 64'(cnt8), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
